uart_cmd_assembler: RTL and testbench

Consumes the byte stream from the UART receiver and assembles two consecutive bytes into a 16-bit command (first byte = high, second byte = low). It drives the receiver's rx_rdy_clr handshake, presents cmd/cmd_rdy to the downstream command processor and discards half-received frames after an inter-byte timeout. It sits directly downstream of the receiver, in place of the LED sink.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/frame_timeout_timer.sv | 41 ++++
 rtl/uart_cmd_assembler.sv | 108 ++++++++++
 tb/tb_uart_cmd_assembler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the byte/command widths, the baud-rate constants the receiver uses,
// the default inter-byte timeout, and the command assembler state type.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int CMD_W  = 16;

  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD_RATE = 19_200;

  // About 2.5 byte times at 50 MHz / 19200 baud between the two halves of a command.
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

  // HIGH waits for the first (high) byte of a command.
  // LOW waits for the second (low) byte of a command.
  typedef enum logic {
    HIGH,
    LOW
  } asm_state_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte timeout counter for the command assembler.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force the count back to zero (takes priority over en)
//   en         : count one step per cycle
//   expired    : one-cycle pulse while enabled at the terminal count
// The count saturates at TIMEOUT_CYCLES-1 rather than wrapping. The owner is
// expected to drop en (or raise clr) once expired has been seen, so the pulse
// lasts a single cycle.
module frame_timeout_timer
  import uart_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] TERMINAL = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  // Count up while enabled and stop at the terminal value, so a long idle
  // period never wraps back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TERMINAL)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en & ~clr & (count == TERMINAL);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles pairs of received UART bytes into 16-bit commands.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   rx_rdy      : receiver has an unconsumed byte on rx_data
//   rx_data     : received byte
//   rx_rdy_clr  : one-cycle pulse telling the receiver the byte was taken
//   cmd         : assembled command {high_byte, low_byte}
//   cmd_rdy     : cmd is valid and has not been acknowledged
//   clr_cmd_rdy : consumer acknowledge, clears cmd_rdy
//   frame_err   : one-cycle pulse when a half-received command is dropped
// The first byte of a frame is the high byte and the second is the low byte.
// If the low byte does not arrive within TIMEOUT_CYCLES of the high byte, the
// partial frame is discarded and the next byte starts a new frame.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_rdy_clr,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  output logic              frame_err
);

  asm_state_t state;
  asm_state_t state_next;
  logic       accept;
  logic       in_low;
  logic       timer_expired;
  logic       timeout_drop;

  // rx_rdy is still high for one cycle after we pulse rx_rdy_clr, because the
  // receiver only clears it on the following edge. Masking with the registered
  // clear keeps that stale cycle from being taken as a second byte.
  assign accept       = rx_rdy & ~rx_rdy_clr;
  assign in_low       = (state == LOW);
  assign timeout_drop = in_low & ~accept & timer_expired;

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~in_low),
    .en     (in_low),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIGH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A byte arriving on the same cycle the timer expires
  // still completes the frame.
  always_comb begin
    state_next = state;
    case (state)
      HIGH: begin
        if (accept) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (accept || timer_expired) begin
          state_next = HIGH;
        end
      end
      default: state_next = HIGH;
    endcase
  end

  // Byte capture, handshake and status outputs. When the cmd_rdy set and the
  // consumer acknowledge land on the same cycle, the set wins so a fresh
  // command is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy_clr <= 1'b0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_rdy_clr <= accept;
      frame_err  <= timeout_drop;
      if (accept && !in_low) begin
        cmd[CMD_W-1:BYTE_W] <= rx_data;
      end
      if (accept && in_low) begin
        cmd[BYTE_W-1:0] <= rx_data;
      end
      if (accept && in_low) begin
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || accept) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard testbench for uart_cmd_assembler (TIMEOUT_CYCLES = 100).
// The stimulus process drives the receiver-side handshake cycle by cycle and
// feeds a frame-level reference model. Completed commands are queued. An
// independent monitor runs on the falling edge, pops a command whenever
// cmd_rdy rises, and compares the per-cycle outputs with the model.
module tb_uart_cmd_assembler;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy_clr;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit running = 0;

  // Reference model state: the expected outputs after the most recent edge,
  // plus the pending first half of a frame.
  logic [15:0] modelCmd = 16'h0000;
  bit          modelRdy = 0;
  bit          modelClr = 0;
  bit          modelErr = 0;
  bit          pending = 0;
  int          pendCyc = 0;
  logic [7:0]  pendByte = 8'h00;
  bit          prevAcc = 0;
  logic [15:0] expQ[$];

  int  errPulses = 0;
  int  clrPulses = 0;
  bit  prevRdy = 0;

  uart_cmd_assembler #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    modelCmd = 16'h0000;
    modelRdy = 0;
    modelClr = 0;
    modelErr = 0;
    pending  = 0;
    prevAcc  = 0;
  endtask

  // A byte counts as taken when the receiver offers it and it was not already
  // taken on the previous edge. A pending high byte pairs with any byte taken
  // within T cycles of it; otherwise it is dropped exactly T cycles after it
  // was taken.
  task automatic modelStep(input bit r, input logic [7:0] d, input bit clr);
    bit acc;
    bit nextRdy;
    acc      = r && !prevAcc;
    nextRdy  = modelRdy;
    modelErr = 0;
    if (clr) nextRdy = 0;
    if (acc && pending && (cyc - pendCyc) <= T) begin
      modelCmd[7:0] = d;
      expQ.push_back({pendByte, d});
      nextRdy = 1;
      pending = 0;
    end else begin
      if (pending && (cyc - pendCyc) == T) begin
        modelErr = 1;
        pending  = 0;
      end
      if (acc) begin
        modelCmd[15:8] = d;
        pendByte = d;
        pendCyc  = cyc;
        pending  = 1;
        nextRdy  = 0;
      end
    end
    modelRdy = nextRdy;
    modelClr = acc;
    prevAcc  = acc;
  endtask

  // Drive one cycle of inputs, then advance past the capturing edge.
  task automatic applyStimulus(input bit r, input logic [7:0] d, input bit clr);
    rx_rdy      = r;
    rx_data     = d;
    clr_cmd_rdy = clr;
    @(posedge clk);
    cyc++;
    modelStep(r, d, clr);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) applyStimulus(1, d, 0);
    for (int i = 0; i < gap; i++) applyStimulus(0, 8'h00, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic doMidReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_rst_clr"}, 16'(rx_rdy_clr), 16'h0);
    checkOutput({tag, "_rst_cmd"}, cmd, 16'h0000);
    checkOutput({tag, "_rst_rdy"}, 16'(cmd_rdy), 16'h0);
    checkOutput({tag, "_rst_err"}, 16'(frame_err), 16'h0);
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  // Monitor: compares outputs against the model on every falling edge and
  // pops the scoreboard when a new command is presented.
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (running && rst_n) begin
        checkOutput("rx_rdy_clr", 16'(rx_rdy_clr), 16'(modelClr));
        checkOutput("frame_err", 16'(frame_err), 16'(modelErr));
        checkOutput("cmd_rdy", 16'(cmd_rdy), 16'(modelRdy));
        checkOutput("cmd_level", cmd, modelCmd);
        if (cmd_rdy && !prevRdy) begin
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL cmd_unexpected at cycle %0d: got %h, expected no command", cyc, cmd);
          end else begin
            exp = expQ.pop_front();
            checkOutput("cmd_frame", cmd, exp);
          end
        end
        if (frame_err) errPulses++;
        if (rx_rdy_clr) clrPulses++;
        prevRdy = cmd_rdy;
      end else begin
        prevRdy = 0;
      end
    end
  end

  initial begin
    int c0;
    int e0;
    int hold;
    int gap;

    // Reset state.
    #1;
    checkOutput("reset_clr", 16'(rx_rdy_clr), 16'h0);
    checkOutput("reset_cmd", cmd, 16'h0000);
    checkOutput("reset_rdy", 16'(cmd_rdy), 16'h0);
    checkOutput("reset_err", 16'(frame_err), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    running = 1;
    idle(2);

    // Basic two-byte frame.
    c0 = clrPulses;
    sendByte(8'hA5, 2, 1);
    sendByte(8'h3C, 2, 1);
    checkOutput("s1_cmd", cmd, 16'hA53C);
    checkOutput("s1_rdy", 16'(cmd_rdy), 16'h1);
    checkOutput("s1_clr_pulses", 16'(clrPulses - c0), 16'd2);
    checkOutput("s1_no_err", 16'(errPulses), 16'd0);

    // Acknowledge, then a second frame.
    applyStimulus(0, 8'h00, 1);
    checkOutput("s2_rdy_cleared", 16'(cmd_rdy), 16'h0);
    checkOutput("s2_cmd_held", cmd, 16'hA53C);
    sendByte(8'h12, 2, 0);
    sendByte(8'h34, 2, 1);
    checkOutput("s2_cmd", cmd, 16'h1234);
    checkOutput("s2_rdy", 16'(cmd_rdy), 16'h1);

    // Lone high byte times out; the next byte starts a new frame.
    e0 = errPulses;
    sendByte(8'h77, 2, 0);
    idle(T + 5);
    checkOutput("s3_err_once", 16'(errPulses - e0), 16'd1);
    checkOutput("s3_rdy", 16'(cmd_rdy), 16'h0);
    sendByte(8'h01, 2, 0);
    sendByte(8'h02, 2, 1);
    checkOutput("s3_cmd", cmd, 16'h0102);

    // Low byte exactly T cycles after the high byte still pairs.
    e0 = errPulses;
    sendByte(8'h55, 2, 0);
    idle(T - 2);
    sendByte(8'hEE, 2, 1);
    checkOutput("s4_cmd", cmd, 16'h55EE);
    checkOutput("s4_rdy", 16'(cmd_rdy), 16'h1);
    checkOutput("s4_no_err", 16'(errPulses - e0), 16'd0);

    // One cycle later it is too late: drop, then the late byte is a high byte.
    sendByte(8'h66, 2, 0);
    idle(T - 1);
    sendByte(8'h99, 2, 0);
    sendByte(8'h44, 2, 1);
    checkOutput("s4b_err", 16'(errPulses - e0), 16'd1);
    checkOutput("s4b_cmd", cmd, 16'h9944);

    // Acknowledge on the same cycle the command completes: set wins.
    sendByte(8'h10, 2, 0);
    applyStimulus(1, 8'h20, 1);
    checkOutput("s5_set_wins", 16'(cmd_rdy), 16'h1);
    checkOutput("s5_cmd", cmd, 16'h1020);
    applyStimulus(1, 8'h20, 0);
    idle(2);

    // rx_rdy stuck high for 5 cycles: accepts on alternate cycles only.
    c0 = clrPulses;
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h5A, 0);
    idle(2);
    checkOutput("s5_stuck_clr", 16'(clrPulses - c0), 16'd3);
    checkOutput("s5_stuck_cmd", cmd, 16'h5A5A);
    sendByte(8'hC3, 2, 1);
    checkOutput("s5_stuck_next", cmd, 16'h5AC3);

    // Reset while a command is waiting, and again mid-frame.
    sendByte(8'hAB, 2, 0);
    sendByte(8'hCD, 2, 0);
    doMidReset("s6a");
    applyStimulus(1, 8'h11, 0);
    doMidReset("s6b");
    idle(1);
    sendByte(8'hBE, 2, 0);
    sendByte(8'hEF, 2, 1);
    checkOutput("s6_cmd", cmd, 16'hBEEF);

    // Randomized traffic with occasional timeouts and acknowledges.
    for (int n = 0; n < 250; n++) begin
      logic [7:0] d;
      d    = 8'($urandom);
      hold = $urandom_range(1, 4);
      gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 5, T + 5) : $urandom_range(0, 6);
      for (int i = 0; i < hold; i++) applyStimulus(1, d, $urandom_range(0, 7) == 0);
      for (int i = 0; i < gap; i++) applyStimulus(0, 8'($urandom), $urandom_range(0, 7) == 0);
    end

    idle(3);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
